// File: rtl/imem_loader.sv
// imem_loader: streams a base/count header plus instruction words into the instruction memory write port.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the data.
module imem_loader #(
   parameter int addr_width_p = 10,
   parameter int data_width_p = 16
) (
   input  logic                    clk,
   input  logic                    n_reset,
   input  logic                    in_valid_i,
   input  logic [data_width_p-1:0] in_data_i,
   output logic                    in_ready_o,
   output logic                    wen_o,
   output logic [addr_width_p-1:0] addr_o,
   output logic [data_width_p-1:0] instruction_o,
   output logic                    nop_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    error_o
);
   localparam logic [2:0] st_addr  = 3'd0;
   localparam logic [2:0] st_count = 3'd1;
   localparam logic [2:0] st_data  = 3'd2;
   localparam logic [2:0] st_done  = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] st_csum  = 3'd4;
   localparam logic [2:0] st_end   = st_csum;
`else
   localparam logic [2:0] st_end   = st_done;
`endif
   localparam logic [31:0] depth_c = 32'd1 << addr_width_p;
   logic [2:0]              state_q, state_d;
   logic [addr_width_p-1:0] cur_q, cur_d, addr_q, addr_d;
   logic [addr_width_p:0]   rem_q, rem_d;
   logic [data_width_p-1:0] instr_q, instr_d, csum_q, csum_d;
   logic                    wen_q, wen_d, error_q, error_d;
   logic                    xfer, clamp;
   logic [31:0]             cnt_w;
   assign in_ready_o    = state_q != st_done;
   assign xfer          = in_valid_i & in_ready_o;
   assign cnt_w         = 32'(in_data_i);
   assign clamp         = cnt_w > depth_c;
   assign wen_o         = wen_q;
   assign addr_o        = addr_q;
   assign instruction_o = instr_q;
   assign busy_o        = state_q != st_addr;
   assign nop_o         = busy_o | wen_q;
   assign done_o        = state_q == st_done;
   assign error_o       = error_q;
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      wen_d   = 1'b0;
      error_d = error_q;
      csum_d  = csum_q;
      if (xfer) begin
         case (state_q)
            st_addr: begin
               cur_d   = in_data_i[addr_width_p-1:0];
               csum_d  = '0;
               state_d = st_count;
            end
            st_count: begin
               rem_d   = clamp ? depth_c[addr_width_p:0] : cnt_w[addr_width_p:0];
               error_d = error_q | clamp;
               state_d = (rem_d == '0) ? st_end : st_data;
            end
            st_data: begin
               wen_d   = 1'b1;
               addr_d  = cur_q;
               instr_d = in_data_i;
               cur_d   = cur_q + addr_width_p'(1);
               rem_d   = rem_q - (addr_width_p+1)'(1);
               csum_d  = csum_q ^ in_data_i;
               state_d = (rem_d == '0) ? st_end : st_data;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            st_csum: begin
               error_d = error_q | (in_data_i != csum_q);
               state_d = st_done;
            end
`endif
            default: ;
         endcase
      end
      if (state_q == st_done) state_d = st_addr;
   end
   // Reset abandons any load; memory contents already written are left alone.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= st_addr;
         cur_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         instr_q <= '0;
         wen_q   <= 1'b0;
         error_q <= 1'b0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         wen_q   <= wen_d;
         error_q <= error_d;
         csum_q  <= csum_d;
      end
   end
endmodule
